// File: rtl/home_auto_pkg.sv
// Shared types and constants for the keypad authentication path.
package home_auto_pkg;

    localparam int BCD_W           = 4;
    localparam int MAX_CODE_DIGITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        GRANTED,
        LOCKOUT
    } auth_state_t;

    function automatic logic is_bcd(input logic [BCD_W-1:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/auth_down_timer.sv
// Loadable down-counter; done is high during the last counted cycle.
module auth_down_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         stop,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (stop)
            cnt <= '0;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/pass_check_fsm.sv
// Keypad access-code checker with entry timeout, fail counter and lockout.
// Define CODE_CHANGE_EN to allow rewriting the stored code while GRANTED.
module pass_check_fsm
    import home_auto_pkg::*;
#(
    parameter int          CODE_DIGITS    = 4,
    parameter logic [31:0] DEFAULT_CODE   = 32'h0000_1234,
    parameter int          MAX_FAILS      = 3,
    parameter int          TIMEOUT_CYCLES = 500,
    parameter int          LOCKOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       key_enter,
    input  logic       key_clear,
    input  logic       logout,
    output logic       pass_check,
    output logic       locked,
    output logic [3:0] fail_cnt,
    output logic [3:0] entry_len
);

    localparam int CW    = BCD_W * CODE_DIGITS;
    localparam int TMAX  = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W = $clog2(TMAX + 1);

    localparam logic [3:0] LEN_FULL = 4'(CODE_DIGITS);
    localparam logic [3:0] LEN_OVF  = 4'(CODE_DIGITS + 1);
    localparam logic [3:0] FAIL_MAX = 4'(MAX_FAILS);

    auth_state_t          state;
    logic [CW-1:0]        entry;
    logic [CW-1:0]        stored_code;
    logic [CW+BCD_W-1:0]  shift_full;
    logic [CW-1:0]        entry_next;
    logic [3:0]           len_inc;
    logic [3:0]           fail_next;
    logic                 match;
    logic                 do_clr, do_ent, do_dig;
    logic                 tmr_load, tmr_stop, tmr_done;
    logic [TMR_W-1:0]     tmr_val;

    // clear > enter > digit; out-of-range digits count as no strobe at all
    assign do_clr = key_clear;
    assign do_ent = key_enter & ~key_clear;
    assign do_dig = key_valid & is_bcd(key_digit) & ~key_clear & ~key_enter;

    assign shift_full = {entry, key_digit};
    assign entry_next = shift_full[CW-1:0];
    assign len_inc    = (entry_len == LEN_OVF) ? LEN_OVF : entry_len + 4'd1;
    assign fail_next  = (fail_cnt >= FAIL_MAX) ? FAIL_MAX : fail_cnt + 4'd1;
    assign match      = (entry_len == LEN_FULL) && (entry == stored_code);

`ifndef CODE_CHANGE_EN
    assign stored_code = DEFAULT_CODE[CW-1:0];
`endif

    // One timer serves both the entry timeout and the lockout period
    always_comb begin
        tmr_load = 1'b0;
        tmr_stop = 1'b0;
        tmr_val  = TMR_W'(TIMEOUT_CYCLES);
        case (state)
            IDLE:  tmr_load = do_dig;
            ENTRY: begin
                if (do_clr || do_ent)
                    tmr_stop = 1'b1;
                else if (do_dig)
                    tmr_load = 1'b1;
            end
            CHECK: begin
                if (!match && fail_next == FAIL_MAX) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(LOCKOUT_CYCLES);
                end
            end
            default: ;
        endcase
    end

    auth_down_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .stop     (tmr_stop),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            entry      <= '0;
            entry_len  <= '0;
            fail_cnt   <= '0;
            pass_check <= 1'b0;
            locked     <= 1'b0;
`ifdef CODE_CHANGE_EN
            stored_code <= DEFAULT_CODE[CW-1:0];
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (do_ent) begin
                        state <= CHECK;
                    end else if (do_dig) begin
                        entry     <= entry_next;
                        entry_len <= 4'd1;
                        state     <= ENTRY;
                    end
                end
                ENTRY: begin
                    if (do_clr) begin
                        entry     <= '0;
                        entry_len <= '0;
                        state     <= IDLE;
                    end else if (do_ent) begin
                        state <= CHECK;
                    end else if (do_dig) begin
                        entry     <= entry_next;
                        entry_len <= len_inc;
                    end else if (tmr_done) begin
                        entry     <= '0;
                        entry_len <= '0;
                        state     <= IDLE;
                    end
                end
                CHECK: begin
                    entry     <= '0;
                    entry_len <= '0;
                    if (match) begin
                        fail_cnt <= '0;
                        state    <= GRANTED;
                    end else begin
                        fail_cnt <= fail_next;
                        if (fail_next == FAIL_MAX) begin
                            locked <= 1'b1;
                            state  <= LOCKOUT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                // pass_check rises on the first edge spent in GRANTED
                GRANTED: begin
                    if (logout) begin
                        pass_check <= 1'b0;
                        entry      <= '0;
                        entry_len  <= '0;
                        state      <= IDLE;
                    end else begin
                        pass_check <= 1'b1;
`ifdef CODE_CHANGE_EN
                        if (do_clr) begin
                            entry     <= '0;
                            entry_len <= '0;
                        end else if (do_ent) begin
                            if (entry_len == LEN_FULL)
                                stored_code <= entry;
                            entry     <= '0;
                            entry_len <= '0;
                        end else if (do_dig) begin
                            entry     <= entry_next;
                            entry_len <= len_inc;
                        end
`endif
                    end
                end
                LOCKOUT: begin
                    if (tmr_done) begin
                        locked   <= 1'b0;
                        fail_cnt <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pass_check_fsm.sv
// Directed table-driven bench for pass_check_fsm plus multi-cycle sequences.
module tb_pass_check_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       key_enter = 1'b0;
    logic       key_clear = 1'b0;
    logic       logout = 1'b0;
    logic       pass_check, locked;
    logic [3:0] fail_cnt, entry_len;

    int checks = 0;
    int failures = 0;

    pass_check_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .key_enter  (key_enter),
        .key_clear  (key_clear),
        .logout     (logout),
        .pass_check (pass_check),
        .locked     (locked),
        .fail_cnt   (fail_cnt),
        .entry_len  (entry_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       e, c, l;
        logic       xp, xl;
        logic [3:0] xf, xn;
    } vec_t;

    vec_t tbl[$];

`ifdef CODE_CHANGE_EN
    localparam int GR_LEN = 1;
`else
    localparam int GR_LEN = 0;
`endif

    function automatic vec_t mk(int v, int d, int e, int c, int l, int xp, int xl, int xf, int xn);
        vec_t r;
        r.v = v[0]; r.d = d[3:0]; r.e = e[0]; r.c = c[0]; r.l = l[0];
        r.xp = xp[0]; r.xl = xl[0]; r.xf = xf[3:0]; r.xn = xn[3:0];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic xp, input logic xl,
                       input logic [3:0] xf, input logic [3:0] xn);
        checks++;
        if ({pass_check, locked, fail_cnt, entry_len} !== {xp, xl, xf, xn}) begin
            failures++;
            $display("FAIL %s: got pass=%0b locked=%0b fail_cnt=%0d entry_len=%0d, want pass=%0b locked=%0b fail_cnt=%0d entry_len=%0d",
                     name, pass_check, locked, fail_cnt, entry_len, xp, xl, xf, xn);
        end
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        step();
        key_valid = 1'b0;
    endtask

    // digits, enter, then the CHECK edge
    task automatic attempt(input logic [31:0] code, input int n);
        for (int i = 0; i < n; i++) press(code[4*(n-1-i) +: 4]);
        key_enter = 1'b1;
        step();
        key_enter = 1'b0;
        step();
    endtask

    task automatic do_logout();
        logout = 1'b1;
        step();
        logout = 1'b0;
    endtask

    initial begin
        // grant path and latency
        tbl.push_back(mk(1,1,0,0,0, 0,0,0,1));
        tbl.push_back(mk(1,2,0,0,0, 0,0,0,2));
        tbl.push_back(mk(1,3,0,0,0, 0,0,0,3));
        tbl.push_back(mk(1,4,0,0,0, 0,0,0,4));
        tbl.push_back(mk(0,0,1,0,0, 0,0,0,4));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,0,0,0));
        tbl.push_back(mk(1,5,0,0,0, 1,0,0,GR_LEN));
        tbl.push_back(mk(0,0,0,0,1, 0,0,0,0));
        // overflow entry fails
        tbl.push_back(mk(1,1,0,0,0, 0,0,0,1));
        tbl.push_back(mk(1,2,0,0,0, 0,0,0,2));
        tbl.push_back(mk(1,3,0,0,0, 0,0,0,3));
        tbl.push_back(mk(1,4,0,0,0, 0,0,0,4));
        tbl.push_back(mk(1,4,0,0,0, 0,0,0,5));
        tbl.push_back(mk(1,7,0,0,0, 0,0,0,5));
        tbl.push_back(mk(0,0,1,0,0, 0,0,0,5));
        tbl.push_back(mk(0,0,0,0,0, 0,0,1,0));
        // short entry fails
        tbl.push_back(mk(1,1,0,0,0, 0,0,1,1));
        tbl.push_back(mk(1,2,0,0,0, 0,0,1,2));
        tbl.push_back(mk(1,3,0,0,0, 0,0,1,3));
        tbl.push_back(mk(0,0,1,0,0, 0,0,1,3));
        tbl.push_back(mk(0,0,0,0,0, 0,0,2,0));
        // invalid digits and strobe priority
        tbl.push_back(mk(1,12,0,0,0, 0,0,2,0));
        tbl.push_back(mk(1,1,0,0,0, 0,0,2,1));
        tbl.push_back(mk(1,15,0,0,0, 0,0,2,1));
        tbl.push_back(mk(1,2,0,1,0, 0,0,2,0));
        tbl.push_back(mk(0,0,1,1,0, 0,0,2,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,2,0));
        tbl.push_back(mk(1,1,0,0,0, 0,0,2,1));
        tbl.push_back(mk(0,0,1,1,0, 0,0,2,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,2,0));
        // grant with digit+enter collision, fail count clears
        tbl.push_back(mk(1,1,0,0,0, 0,0,2,1));
        tbl.push_back(mk(1,2,0,0,0, 0,0,2,2));
        tbl.push_back(mk(1,3,0,0,0, 0,0,2,3));
        tbl.push_back(mk(1,4,0,0,0, 0,0,2,4));
        tbl.push_back(mk(1,9,1,0,0, 0,0,2,4));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,0,0,0));
        tbl.push_back(mk(0,0,0,0,1, 0,0,0,0));
        // enter with empty entry is a failure
        tbl.push_back(mk(0,0,1,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,1,0));

        #1;
        chk("reset", 1'b0, 1'b0, 4'd0, 4'd0);
        #12 rst_n = 1'b1;

        foreach (tbl[i]) begin
            key_valid = tbl[i].v;
            key_digit = tbl[i].d;
            key_enter = tbl[i].e;
            key_clear = tbl[i].c;
            logout    = tbl[i].l;
            step();
            chk($sformatf("vec[%0d]", i), tbl[i].xp, tbl[i].xl, tbl[i].xf, tbl[i].xn);
        end
        key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0; logout = 1'b0;

        // entry timeout; an invalid digit must not restart it
        press(4'd1);
        chk("to_start", 1'b0, 1'b0, 4'd1, 4'd1);
        for (int i = 1; i <= 499; i++) begin
            if (i == 200) begin key_valid = 1'b1; key_digit = 4'd15; end
            step();
            key_valid = 1'b0;
        end
        chk("to_499", 1'b0, 1'b0, 4'd1, 4'd1);
        step();
        chk("to_500", 1'b0, 1'b0, 4'd1, 4'd0);
        step();
        chk("to_idle", 1'b0, 1'b0, 4'd1, 4'd0);

        attempt(32'h1234, 4);
        step();
        chk("grant2", 1'b1, 1'b0, 4'd0, 4'd0);
        do_logout();
        chk("logout2", 1'b0, 1'b0, 4'd0, 4'd0);

        // three failures -> lockout of 1000 cycles
        for (int k = 1; k <= 3; k++) begin
            attempt(32'h1235, 4);
            chk($sformatf("fail_%0d", k), 1'b0, k == 3, 4'(k), 4'd0);
        end
        for (int i = 1; i <= 999; i++) begin
            if (i <= 4) begin key_valid = 1'b1; key_digit = 4'(i); end
            if (i == 5) key_enter = 1'b1;
            if (i == 6) logout = 1'b1;
            step();
            key_valid = 1'b0; key_enter = 1'b0; logout = 1'b0;
            if (i == 4 || i == 7 || i == 999)
                chk($sformatf("lock_%0d", i), 1'b0, 1'b1, 4'd3, 4'd0);
        end
        step();
        chk("lock_end", 1'b0, 1'b0, 4'd0, 4'd0);
        attempt(32'h1234, 4);
        step();
        chk("grant_after_lock", 1'b1, 1'b0, 4'd0, 4'd0);

        // asynchronous reset while GRANTED
        #2 rst_n = 1'b0;
        #1 chk("rst_granted", 1'b0, 1'b0, 4'd0, 4'd0);
        #1 rst_n = 1'b1;
        step();
        chk("post_rst_granted", 1'b0, 1'b0, 4'd0, 4'd0);

        // asynchronous reset while LOCKOUT
        for (int k = 1; k <= 3; k++) attempt(32'h5678, 4);
        chk("lock_again", 1'b0, 1'b1, 4'd3, 4'd0);
        for (int i = 0; i < 5; i++) step();
        #2 rst_n = 1'b0;
        #1 chk("rst_lockout", 1'b0, 1'b0, 4'd0, 4'd0);
        #1 rst_n = 1'b1;
        step();
        chk("post_rst_lockout", 1'b0, 1'b0, 4'd0, 4'd0);
        attempt(32'h1234, 4);
        step();
        chk("grant_after_rst", 1'b1, 1'b0, 4'd0, 4'd0);
        do_logout();

`ifdef CODE_CHANGE_EN
        attempt(32'h1234, 4);
        step();
        for (int i = 0; i < 4; i++) press(4'(9 - i));
        chk("cc_entry", 1'b1, 1'b0, 4'd0, 4'd4);
        key_enter = 1'b1;
        step();
        key_enter = 1'b0;
        chk("cc_write", 1'b1, 1'b0, 4'd0, 4'd0);
        do_logout();
        attempt(32'h1234, 4);
        chk("cc_old_fails", 1'b0, 1'b0, 4'd1, 4'd0);
        attempt(32'h9876, 4);
        step();
        chk("cc_new_grants", 1'b1, 1'b0, 4'd0, 4'd0);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        attempt(32'h1234, 4);
        step();
        chk("cc_default_back", 1'b1, 1'b0, 4'd0, 4'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
